// File: rtl/fetch_unit.sv
// Instruction-fetch front end.
// Drives the instruction-memory address and captures the returned word one
// cycle later. PC/instruction pairs go to decode through a valid/ready
// handshake, with a 2-entry output buffer absorbing backpressure. A redirect
// flushes everything that is in flight or buffered.
//
// The buffer is a head register and a tail register. The head register is
// the decode-facing output, so dec_* come straight from flops. Empty slots
// are kept at zero, so an idle output reads as all zeros.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] PC,
   input  logic [31:0] ins,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        dec_valid,
   input  logic        dec_ready,
   output logic [31:0] dec_pc,
   output logic [31:0] dec_ins
);

   localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

   logic [31:0] pc_q;
   logic        infl_v;
   logic [31:0] infl_pc;

   logic        head_v;
   logic [31:0] head_pc;
   logic [31:0] head_ins;
   logic        tail_v;
   logic [31:0] tail_pc;
   logic [31:0] tail_ins;

   logic        deq;
   logic        push;
   logic [1:0]  occ;
   logic [2:0]  lvl;
   logic        issue;
   logic [31:0] new_pc;
   logic [31:0] new_ins;
   logic [31:0] redirect_target;

   // Handshake, capture and issue decisions for the current cycle.
   always_comb begin
      deq             = head_v & dec_ready;
      push            = infl_v & ~redirect_valid;
      occ             = {1'b0, head_v} + {1'b0, tail_v};
      // Entries that will be held after this edge, counting the word coming
      // back from memory. Issuing only while this fits leaves room for the
      // fetch issued now, so the buffer never overflows.
      lvl             = {1'b0, occ} + {2'b00, infl_v} - {2'b00, deq};
      issue           = (lvl < 3'(BUF_DEPTH));
      new_pc          = push ? infl_pc : 32'h0;
      new_ins         = push ? ins : 32'h0;
      redirect_target = redirect_pc & ALIGN_MASK;
   end

   // Fetch address and in-flight tracking.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= RESET_PC & ALIGN_MASK;
         infl_v  <= 1'b0;
         infl_pc <= 32'h0;
      end else if (redirect_valid) begin
         // The word returning this cycle belongs to the old path. The target
         // is issued next cycle, when the buffer is empty.
         pc_q   <= redirect_target;
         infl_v <= 1'b0;
      end else if (issue) begin
         pc_q    <= pc_q + 32'd4;
         infl_v  <= 1'b1;
         infl_pc <= pc_q;
      end else begin
         // Memory keeps reading pc_q. Its next word is not captured.
         infl_v <= 1'b0;
      end
   end

   // Two-slot output buffer. The head slot is what decode sees.
   always_ff @(posedge clk) begin
      if (rst || redirect_valid) begin
         // A handshake in a redirect cycle is still taken by decode. Only the
         // entries behind it are dropped.
         head_v   <= 1'b0;
         head_pc  <= 32'h0;
         head_ins <= 32'h0;
         tail_v   <= 1'b0;
         tail_pc  <= 32'h0;
         tail_ins <= 32'h0;
      end else if (deq) begin
         if (tail_v) begin
            head_pc  <= tail_pc;
            head_ins <= tail_ins;
            tail_v   <= push;
            tail_pc  <= new_pc;
            tail_ins <= new_ins;
         end else begin
            head_v   <= push;
            head_pc  <= new_pc;
            head_ins <= new_ins;
         end
      end else if (!head_v) begin
         head_v   <= push;
         head_pc  <= new_pc;
         head_ins <= new_ins;
      end else if (!tail_v) begin
         tail_v   <= push;
         tail_pc  <= new_pc;
         tail_ins <= new_ins;
      end
   end

   assign PC        = pc_q;
   assign dec_valid = head_v;
   assign dec_pc    = head_pc;
   assign dec_ins   = head_ins;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit.
// The expected stream is a queue of addresses in fetch order. It restarts at
// every reset and redirect target, and a monitor pops it on each handshake.
// Instruction memory is modelled as ins = address ^ KEY, returned one cycle
// after the address.
module tb_fetch_unit;

   localparam logic [31:0] KEY     = 32'hA5A5_0000;
   localparam logic [31:0] RST_A   = 32'h0000_0000;
   localparam logic [31:0] RST_W   = 32'hFFFF_FFF8;

   logic        clk;
   logic        rst;
   logic [31:0] pc;
   logic [31:0] ins;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        dec_valid;
   logic        dec_ready;
   logic [31:0] dec_pc;
   logic [31:0] dec_ins;

   logic        rst_w;
   logic [31:0] pc_w;
   logic [31:0] ins_w;
   logic        dec_valid_w;
   logic [31:0] dec_pc_w;
   logic [31:0] dec_ins_w;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];
   logic [31:0] gen_next = RST_A;

   fetch_unit #(.RESET_PC(RST_A), .BUF_DEPTH(2)) dut (
      .clk(clk), .rst(rst), .PC(pc), .ins(ins),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .dec_valid(dec_valid), .dec_ready(dec_ready),
      .dec_pc(dec_pc), .dec_ins(dec_ins)
   );

   fetch_unit #(.RESET_PC(RST_W), .BUF_DEPTH(2)) dut_w (
      .clk(clk), .rst(rst_w), .PC(pc_w), .ins(ins_w),
      .redirect_valid(1'b0), .redirect_pc(32'h0),
      .dec_valid(dec_valid_w), .dec_ready(1'b1),
      .dec_pc(dec_pc_w), .dec_ins(dec_ins_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory: word for the address sampled at this edge.
   always @(posedge clk) begin
      ins   <= pc ^ KEY;
      ins_w <= pc_w ^ KEY;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic sb_restart(input logic [31:0] start);
      exp_q.delete();
      gen_next = start;
   endtask

   // Advance one cycle. A redirect driven in the previous cycle restarts the
   // expected stream after its edge. The stream is kept topped up.
   task automatic tick();
      @(posedge clk);
      #1;
      if (redirect_valid) begin
         sb_restart(redirect_pc & 32'hFFFF_FFFC);
         redirect_valid = 1'b0;
      end
      while (exp_q.size() < 16) begin
         exp_q.push_back(gen_next);
         gen_next = gen_next + 32'd4;
      end
   endtask

   // Monitor: compare every accepted entry against the expected stream, and
   // check that an idle output reads zero.
   always @(negedge clk) begin
      if (!rst) begin
         if (dec_valid && dec_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL sb_empty: got dec_pc %08h expected no entry", dec_pc);
            end else begin
               logic [31:0] e;
               e = exp_q.pop_front();
               check("sb_pc", dec_pc, e);
               check("sb_ins", dec_ins, e ^ KEY);
            end
         end
         if (!dec_valid) begin
            check("idle_pc", dec_pc, 32'h0);
            check("idle_ins", dec_ins, 32'h0);
         end
      end
   end

   // Reset, release, and check first-fetch latency.
   task automatic reset_seq();
      rst            = 1'b1;
      dec_ready      = 1'b1;
      redirect_valid = 1'b0;
      tick();
      tick();
      check("rst_pc", pc, RST_A);
      check("rst_valid", 32'(dec_valid), 32'd0);
      check("rst_dec_pc", dec_pc, 32'h0);
      check("rst_dec_ins", dec_ins, 32'h0);
      rst = 1'b0;
      sb_restart(RST_A);
      tick();
      check("lat1_valid", 32'(dec_valid), 32'd0);
      check("lat1_pc", pc, RST_A + 32'd4);
      tick();
      check("lat2_valid", 32'(dec_valid), 32'd1);
      check("lat2_dec_pc", dec_pc, RST_A);
   endtask

   initial begin
      bit found;
      rst            = 1'b1;
      rst_w          = 1'b1;
      dec_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;

      // Reset release and full-rate streaming.
      reset_seq();
      for (int k = 1; k <= 6; k++) begin
         tick();
         check("stream_valid", 32'(dec_valid), 32'd1);
         check("stream_pc", dec_pc, RST_A + 32'(4 * k));
      end

      // Backpressure while 0x8 is presented.
      reset_seq();
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (dec_valid && dec_pc == 32'h8) found = 1'b1;
         else tick();
      end
      if (!found) begin
         n_cmp++;
         n_err++;
         $display("FAIL bp_wait: got no dec_pc 00000008 expected it within 20 cycles");
      end
      dec_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_valid", 32'(dec_valid), 32'd1);
         check("bp_hold_pc", dec_pc, 32'h8);
         check("bp_hold_ins", dec_ins, 32'h8 ^ KEY);
         check("bp_fetch_pc", pc, 32'h10);
      end
      dec_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("bp_resume_pc", dec_pc, 32'hC + 32'(4 * k));
      end

      // Redirect while the buffer is full.
      dec_ready = 1'b0;
      tick();
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      tick();
      check("redir_valid0", 32'(dec_valid), 32'd0);
      check("redir_fetch_pc", pc, 32'h100);
      dec_ready = 1'b1;
      tick();
      check("redir_valid1", 32'(dec_valid), 32'd0);
      tick();
      check("redir_valid2", 32'(dec_valid), 32'd1);
      check("redir_pc0", dec_pc, 32'h100);
      tick();
      check("redir_pc1", dec_pc, 32'h104);

      // Misaligned redirect in the same cycle as a handshake.
      redirect_valid = 1'b1;
      redirect_pc    = 32'h203;
      tick();
      check("redir_hs_valid", 32'(dec_valid), 32'd0);
      check("redir_hs_fetch", pc, 32'h200);
      tick();
      tick();
      check("redir_hs_pc", dec_pc, 32'h200);

      // Random backpressure and redirects.
      for (int i = 0; i < 400; i++) begin
         dec_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 19) == 0) begin
            redirect_valid = 1'b1;
            redirect_pc    = $urandom;
         end
         tick();
      end

      // Reset mid-stream with a full buffer; the restart must match the first run.
      dec_ready = 1'b0;
      tick();
      tick();
      reset_seq();
      for (int k = 1; k <= 6; k++) begin
         tick();
         check("restart_pc", dec_pc, RST_A + 32'(4 * k));
      end

      // Address wrap from the top of the address space.
      tick();
      tick();
      rst_w = 1'b0;
      tick();
      check("wrap_lat_valid", 32'(dec_valid_w), 32'd0);
      for (int k = 0; k < 4; k++) begin
         logic [31:0] a;
         a = RST_W + 32'(4 * k);
         tick();
         check("wrap_valid", 32'(dec_valid_w), 32'd1);
         check("wrap_pc", dec_pc_w, a);
         check("wrap_ins", dec_ins_w, a ^ KEY);
      end

      tick();
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
